rbz_spi_reg_ctrl: RTL

// - SPI-slave configuration controller for the rbzero raycaster: receives register writes over SPI
//   (ui_in[0..2]), holds them in a shadow bank and commits them to the live bank at vblank start.
// - The live bank drives the raycaster view vectors / config, so updates never tear mid-frame.
// - Sits between the top-level pin mapping and rbzero's datapath.
//

---
 rtl/rbz_spi_reg_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/rbz_spi_reg_ctrl.sv
// SPI-slave register bank for the rbzero raycaster: SPI frames land in a shadow bank that is
// copied to the live bank at vblank start. Define RBZ_SPI_MISO_EN to build live-bank readback on o_miso.
module rbz_spi_reg_ctrl #(
  parameter int                ADDR_W    = 3,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_sclk,
  input  logic                             i_mosi,
  input  logic                             i_ss_n,
  input  logic                             i_vblank,
  output logic                             o_miso,
  output logic [(2**ADDR_W)*DATA_W-1:0]    o_regs,
  output logic                             o_wr_strobe,
  output logic                             o_commit,
  output logic                             o_frame_err,
  output logic                             o_busy
);

  localparam int NREGS   = 2**ADDR_W;
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         sclk_sync_q, sclk_sync_d;
  logic [1:0]         ss_sync_q, ss_sync_d;
  logic [1:0]         mosi_sync_q, mosi_sync_d;
  logic               vblank_q, vblank_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0]  shadow_q [NREGS];
  logic [DATA_W-1:0]  shadow_d [NREGS];
  logic [DATA_W-1:0]  live_q [NREGS];
  logic [DATA_W-1:0]  live_d [NREGS];
  logic [NREGS-1:0]   pending_q, pending_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic               commit_q, commit_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;

  logic               sclk_rise_s;
  logic               ss_n_s;
  logic               mosi_s;
  logic               vblank_rise_s;
  logic [FRAME_W-1:0] frame_s;
  logic [ADDR_W-1:0]  frame_addr_s;
  logic [DATA_W-1:0]  frame_data_s;
  logic [NREGS-1:0]   wr_mask_s;
  logic [NREGS-1:0]   commit_mask_s;

  // Synchroniser taps; frame_s includes the bit being sampled this cycle.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], i_sclk};
    ss_sync_d    = {ss_sync_q[0], i_ss_n};
    mosi_sync_d  = {mosi_sync_q[0], i_mosi};
    vblank_d     = i_vblank;
    sclk_rise_s  = sclk_sync_q[1] & ~sclk_sync_q[2];
    ss_n_s       = ss_sync_q[1];
    mosi_s       = mosi_sync_q[1];
    frame_s      = {shift_q, mosi_s};
    frame_addr_s = frame_s[FRAME_W-1 -: ADDR_W];
    frame_data_s = frame_s[DATA_W-1:0];
  end

  // Frame FSM: DONE swallows trailing bits so an over-long frame writes only once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    wr_mask_s   = {NREGS{1'b0}};
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ss_n_s) begin
          state_d = ST_SHIFT;
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {(FRAME_W-1){1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ss_n_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise_s) begin
          shift_d = {shift_q[FRAME_W-3:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            wr_mask_s = {{(NREGS-1){1'b0}}, 1'b1} << frame_addr_s;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (ss_n_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    wr_strobe_d = |wr_mask_s;
    busy_d      = (state_d != ST_IDLE);
  end

  // Commit reads the pre-write shadow, so a same-cycle write stays pending for the next vblank.
  always_comb begin
    vblank_rise_s = i_vblank & ~vblank_q;
    commit_mask_s = vblank_rise_s ? pending_q : {NREGS{1'b0}};
    for (int n = 0; n < NREGS; n++) begin
      shadow_d[n] = wr_mask_s[n] ? frame_data_s : shadow_q[n];
      live_d[n]   = commit_mask_s[n] ? shadow_q[n] : live_q[n];
    end
    pending_d = (pending_q & ~commit_mask_s) | wr_mask_s;
    commit_d  = |commit_mask_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      vblank_q    <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      shift_q     <= {(FRAME_W-1){1'b0}};
      pending_q   <= {NREGS{1'b0}};
      wr_strobe_q <= 1'b0;
      commit_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int n = 0; n < NREGS; n++) begin
        shadow_q[n] <= RESET_VAL;
        live_q[n]   <= RESET_VAL;
      end
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vblank_q    <= vblank_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pending_q   <= pending_d;
      wr_strobe_q <= wr_strobe_d;
      commit_q    <= commit_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      shadow_q    <= shadow_d;
      live_q      <= live_d;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign o_regs[g*DATA_W +: DATA_W] = live_q[g];
  end

  assign o_wr_strobe = wr_strobe_q;
  assign o_commit    = commit_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;

`ifdef RBZ_SPI_MISO_EN
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              sclk_fall_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Readback loads the committed value once the address is complete, then shifts on falling edges.
  always_comb begin
    sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    rd_addr_s   = frame_s[ADDR_W-1:0];
    if (state_q != ST_SHIFT) begin
      tx_d = {DATA_W{1'b0}};
    end else if (sclk_rise_s && (cnt_q == CNT_W'(ADDR_W - 1))) begin
      tx_d = live_q[rd_addr_s];
    end else if (sclk_fall_s) begin
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end else begin
      tx_d = tx_q;
    end
    miso_d = (state_d == ST_SHIFT) ? tx_d[DATA_W-1] : 1'b0;
  end

  // Readback registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q   <= {DATA_W{1'b0}};
      miso_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      miso_q <= miso_d;
    end
  end

  assign o_miso = miso_q;
`else
  assign o_miso = 1'b0;
`endif

endmodule
